// File: rtl/csa_sub_seq_if.sv
// Start/done bus for csa_sub_seq. The ovf signal exists only when CSA_SUB_OVF_EN is defined.
// Handshake: a request is taken on the rising edge where start=1 and ready=1; done is a
// single-cycle pulse, and diff/bout (and ovf) stay valid from done until the next done.
interface csa_sub_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef CSA_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input ready, busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output ready, busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input ready, busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output ready, busy, done, diff, bout);
`endif
endinterface

// File: rtl/csa_sub_seq.sv
// Sequential ripple-borrow subtractor: diff = a - b - bin, one DIGIT-bit slice per clock.
// Optional signed-overflow flag is enabled by defining CSA_SUB_OVF_EN.
module csa_sub_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  csa_sub_seq_if.slave bus,
  output logic [1:0]  state_dbg
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef CSA_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] a_slice, b_slice;
  logic [DIGIT:0]   slice_sum;

  // Subtraction as a + ~b + ~borrow; the slice's carry-out is the inverted borrow-out.
  always_comb begin
    a_slice   = a_q[cnt_q*DIGIT +: DIGIT];
    b_slice   = b_q[cnt_q*DIGIT +: DIGIT];
    slice_sum = {1'b0, a_slice} + {1'b0, ~b_slice} + {{DIGIT{1'b0}}, ~borrow_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    work_d   = work_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef CSA_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          work_d   = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        work_d[cnt_q*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
        borrow_d = ~slice_sum[DIGIT];
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = work_d;
          bout_d  = ~slice_sum[DIGIT];
`ifdef CSA_SUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      work_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef CSA_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef CSA_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
`ifdef CSA_SUB_OVF_EN
  assign bus.ovf   = ovf_q;
`endif
  assign state_dbg = state_q;
endmodule

// File: tb/tb_csa_sub_seq.sv
// Scoreboard bench for csa_sub_seq: the driver pushes model results, the monitor pops on done.
module tb_csa_sub_seq;
  localparam int W = 16;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  csa_sub_seq_if #(.WIDTH(W)) bus ();

  csa_sub_seq #(.WIDTH(W), .DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_bout_q[$];
  int           exp_cyc_q[$];
`ifdef CSA_SUB_OVF_EN
  logic         exp_ovf_q[$];
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the unsigned operands.
  task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                            input int acc_cyc);
    int d;
    d = int'(a) - int'(b) - int'(bin);
    exp_q.push_back(W'(d & 32'h0000_FFFF));
    exp_bout_q.push_back(int'(a) < int'(b) + int'(bin));
    exp_cyc_q.push_back(acc_cyc + N);
`ifdef CSA_SUB_OVF_EN
    exp_ovf_q.push_back((a[W-1] != b[W-1]) && (W'(d & 32'h0000_FFFF) >> (W-1) != {15'd0, a[W-1]}));
`endif
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] last_diff;
  logic         last_bout;
  logic         hold_chk = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("diff", bus.diff, exp_q.pop_front());
          chk("bout", bus.bout, exp_bout_q.pop_front());
          chk("latency_cycle", cyc, exp_cyc_q.pop_front());
`ifdef CSA_SUB_OVF_EN
          chk("ovf", bus.ovf, exp_ovf_q.pop_front());
`endif
          chk("busy_at_done", bus.busy, 32'd0);
        end
        last_diff = bus.diff;
        last_bout = bus.bout;
        hold_chk  = 1'b1;
      end else if (hold_chk) begin
        chk("diff_hold", bus.diff, last_diff);
        chk("bout_hold", bus.bout, last_bout);
        hold_chk = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  int prev_acc = -100;

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit hold, input bit chk_gap);
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      if (chk_gap) chk("issue_gap", cyc + 1 - prev_acc, N + 2);
      prev_acc = cyc + 1;
      push_model(a, b, bin, cyc + 1);
      if (!hold) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.ready, 32'd1);
    chk("rst_busy",  bus.busy,  32'd0);
    chk("rst_done",  bus.done,  32'd0);
    chk("rst_diff",  bus.diff,  32'd0);
    chk("rst_bout",  bus.bout,  32'd0);

    // directed boundary cases
    issue(16'h0004, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // start re-pulsed while running must be ignored
    issue(16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("busy_in_run", bus.busy, 32'd1);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    // reset in the second RUN cycle discards the op
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h5555;
    bus.b     = 16'h1111;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bus.ready, 32'd1);
    chk("midrst_busy",  bus.busy,  32'd0);
    chk("midrst_diff",  bus.diff,  32'd0);
    chk("midrst_bout",  bus.bout,  32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // start held high: back-to-back ops every N+2 cycles
    for (int i = 0; i < 20; i++) begin
      issue(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 1)), 1'b1, i > 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    // pulsed random ops with idle gaps
    for (int i = 0; i < 20; i++) begin
      issue(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 1)), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
